// File: rtl/gelato_operand_collector_banked.sv
// Banked operand collector: buffers issued instructions, gathers source operands from a
// multi-bank register file through tagged requests, and dispatches ready instructions per unit.
module gelato_operand_collector_banked #(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_SRC     = 3,
  parameter int NUM_UNITS   = 3,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WARP_W      = 2,
  parameter int INST_W      = 64
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   rdy,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [INST_W-1:0]                                      in_inst,
  input  logic [NUM_SRC*REG_W-1:0]                               in_rs,
  input  logic [WARP_W-1:0]                                      in_warp,
  input  logic [$clog2(NUM_UNITS)-1:0]                           in_unit,
  output logic [NUM_BANKS-1:0]                                   req_valid,
  input  logic [NUM_BANKS-1:0]                                   req_ready,
  output logic [NUM_BANKS*(WARP_W+REG_W)-1:0]                    req_reg,
  output logic [NUM_BANKS*($clog2(NUM_ENTRIES)+$clog2(NUM_SRC))-1:0] req_tag,
  input  logic [NUM_BANKS-1:0]                                   rsp_valid,
  input  logic [NUM_BANKS*($clog2(NUM_ENTRIES)+$clog2(NUM_SRC))-1:0] rsp_tag,
  input  logic [NUM_BANKS*DATA_W-1:0]                            rsp_data,
  output logic [NUM_UNITS-1:0]                                   disp_valid,
  input  logic [NUM_UNITS-1:0]                                   disp_ready,
  output logic [NUM_UNITS*INST_W-1:0]                            disp_inst,
  output logic [NUM_UNITS*NUM_SRC*DATA_W-1:0]                    disp_src
);
  localparam int ENT_W   = $clog2(NUM_ENTRIES);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int UNIT_W  = $clog2(NUM_UNITS);
  localparam int TAG_W   = ENT_W + SRC_W;
  localparam int PREG_W  = WARP_W + REG_W;
  localparam int NUM_OPS = NUM_ENTRIES * NUM_SRC;
  localparam int OP_W    = $clog2(NUM_OPS);

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_PEND  = 2'd1;
  localparam logic [1:0] OP_INFL  = 2'd2;
  localparam logic [1:0] OP_READY = 2'd3;

  // Operands are stored flat: index = entry*NUM_SRC + src.
  function automatic logic [OP_W-1:0] op_of(input logic [ENT_W-1:0] e, input logic [SRC_W-1:0] s);
    return OP_W'(int'(e) * NUM_SRC + int'(s));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [OP_W-1:0] k);
    return {ENT_W'(int'(k) / NUM_SRC), SRC_W'(int'(k) % NUM_SRC)};
  endfunction

  function automatic logic [OP_W-1:0] rr_pick(input logic [NUM_OPS-1:0] mask,
                                              input logic [OP_W-1:0] last, input int n);
    logic [OP_W-1:0] pick;
    logic            found;
    int              j;
    pick  = {OP_W{1'b0}};
    found = 1'b0;
    for (int i = 1; i <= NUM_OPS; i++) begin
      j = (int'(last) + i) % n;
      if (i <= n && !found && mask[j]) begin
        pick  = OP_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [NUM_ENTRIES-1:0] ent_valid_r;
  logic [INST_W-1:0]      ent_inst_r [NUM_ENTRIES];
  logic [UNIT_W-1:0]      ent_unit_r [NUM_ENTRIES];
  logic [1:0]             op_state_r [NUM_OPS];
  logic [PREG_W-1:0]      op_preg_r  [NUM_OPS];
  logic [DATA_W-1:0]      op_data_r  [NUM_OPS];
  logic [NUM_BANKS-1:0]   req_hold_r;
  logic [OP_W-1:0]        req_hold_idx_r [NUM_BANKS];
  logic [OP_W-1:0]        req_last_r     [NUM_BANKS];
  logic [NUM_UNITS-1:0]   disp_hold_r;
  logic [OP_W-1:0]        disp_hold_idx_r [NUM_UNITS];
  logic [OP_W-1:0]        disp_last_r     [NUM_UNITS];

  logic                   active_s;
  logic                   any_free_s;
  logic [ENT_W-1:0]       alloc_idx_s;
  logic [NUM_OPS-1:0]     req_mask_s [NUM_BANKS];
  logic [OP_W-1:0]        req_sel_s  [NUM_BANKS];
  logic [NUM_BANKS-1:0]   req_any_s;
  logic [NUM_ENTRIES-1:0] elig_s;
  logic [NUM_OPS-1:0]     disp_mask_s [NUM_UNITS];
  logic [OP_W-1:0]        disp_sel_s  [NUM_UNITS];
  logic [NUM_UNITS-1:0]   disp_any_s;
  logic [NUM_BANKS-1:0]   rsp_ok_s;
  logic [OP_W-1:0]        rsp_op_s [NUM_BANKS];

  assign active_s = rdy & rst_n;

  // Lowest free entry for allocation.
  always_comb begin
    alloc_idx_s = {ENT_W{1'b0}};
    any_free_s  = ~(&ent_valid_r);
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      alloc_idx_s = ent_valid_r[e] ? alloc_idx_s : ENT_W'(e);
    end
    in_ready = active_s & any_free_s;
  end

  // Per-bank round-robin over pending operands, locked while a request waits.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_mask_s[b] = {NUM_OPS{1'b0}};
      for (int k = 0; k < NUM_OPS; k++) begin
        req_mask_s[b][k] = (op_state_r[k] == OP_PEND) && (op_preg_r[k][BANK_W-1:0] == BANK_W'(b));
      end
      req_sel_s[b] = req_hold_r[b] ? req_hold_idx_r[b] : rr_pick(req_mask_s[b], req_last_r[b], NUM_OPS);
      req_any_s[b] = req_hold_r[b] | (|req_mask_s[b]);
      req_valid[b] = active_s & req_any_s[b];
      req_reg[b*PREG_W +: PREG_W] = op_preg_r[req_sel_s[b]];
      req_tag[b*TAG_W +: TAG_W]   = tag_of(req_sel_s[b]);
    end
  end

  // Response decode: only tags pointing at an in-flight operand are accepted.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      rsp_op_s[b] = op_of(rsp_tag[b*TAG_W + SRC_W +: ENT_W], rsp_tag[b*TAG_W +: SRC_W]);
      rsp_ok_s[b] = rsp_valid[b] && (int'(rsp_tag[b*TAG_W +: SRC_W]) < NUM_SRC)
                    && (op_state_r[rsp_op_s[b]] == OP_INFL);
    end
  end

  // Per-unit round-robin over fully collected entries, locked until accepted.
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      elig_s[e] = ent_valid_r[e];
      for (int s = 0; s < NUM_SRC; s++) begin
        elig_s[e] = elig_s[e] & (op_state_r[e*NUM_SRC+s] == OP_READY);
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      disp_mask_s[u] = {NUM_OPS{1'b0}};
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        disp_mask_s[u][e] = elig_s[e] & (ent_unit_r[e] == UNIT_W'(u));
      end
      disp_sel_s[u] = disp_hold_r[u] ? disp_hold_idx_r[u]
                                     : rr_pick(disp_mask_s[u], disp_last_r[u], NUM_ENTRIES);
      disp_any_s[u] = disp_hold_r[u] | (|disp_mask_s[u]);
      disp_valid[u] = active_s & disp_any_s[u];
      disp_inst[u*INST_W +: INST_W] = ent_inst_r[disp_sel_s[u][ENT_W-1:0]];
      for (int s = 0; s < NUM_SRC; s++) begin
        disp_src[(u*NUM_SRC+s)*DATA_W +: DATA_W] = op_data_r[op_of(disp_sel_s[u][ENT_W-1:0], SRC_W'(s))];
      end
    end
  end

  // Collector state: responses always land; everything else advances only when rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_valid_r <= {NUM_ENTRIES{1'b0}};
      req_hold_r  <= {NUM_BANKS{1'b0}};
      disp_hold_r <= {NUM_UNITS{1'b0}};
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        ent_inst_r[e] <= {INST_W{1'b0}};
        ent_unit_r[e] <= {UNIT_W{1'b0}};
      end
      for (int k = 0; k < NUM_OPS; k++) begin
        op_state_r[k] <= OP_IDLE;
        op_preg_r[k]  <= {PREG_W{1'b0}};
        op_data_r[k]  <= {DATA_W{1'b0}};
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        req_hold_idx_r[b] <= {OP_W{1'b0}};
        req_last_r[b]     <= {OP_W{1'b0}};
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        disp_hold_idx_r[u] <= {OP_W{1'b0}};
        disp_last_r[u]     <= {OP_W{1'b0}};
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rsp_ok_s[b]) begin
          op_state_r[rsp_op_s[b]] <= OP_READY;
          op_data_r[rsp_op_s[b]]  <= rsp_data[b*DATA_W +: DATA_W];
        end
      end
      if (rdy) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (req_valid[b] && req_ready[b]) begin
            op_state_r[req_sel_s[b]] <= OP_INFL;
            req_last_r[b]            <= req_sel_s[b];
            req_hold_r[b]            <= 1'b0;
          end else if (req_valid[b]) begin
            req_hold_r[b]     <= 1'b1;
            req_hold_idx_r[b] <= req_sel_s[b];
          end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (disp_valid[u] && disp_ready[u]) begin
            ent_valid_r[disp_sel_s[u][ENT_W-1:0]] <= 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
              op_state_r[op_of(disp_sel_s[u][ENT_W-1:0], SRC_W'(s))] <= OP_IDLE;
            end
            disp_last_r[u] <= disp_sel_s[u];
            disp_hold_r[u] <= 1'b0;
          end else if (disp_valid[u]) begin
            disp_hold_r[u]     <= 1'b1;
            disp_hold_idx_r[u] <= disp_sel_s[u];
          end
        end
        if (in_valid && in_ready) begin
          ent_valid_r[alloc_idx_s] <= 1'b1;
          ent_inst_r[alloc_idx_s]  <= in_inst;
          ent_unit_r[alloc_idx_s]  <= in_unit;
          for (int s = 0; s < NUM_SRC; s++) begin
            op_preg_r[op_of(alloc_idx_s, SRC_W'(s))]  <= {in_warp, in_rs[s*REG_W +: REG_W]};
            op_data_r[op_of(alloc_idx_s, SRC_W'(s))]  <= {DATA_W{1'b0}};
            op_state_r[op_of(alloc_idx_s, SRC_W'(s))] <=
              (in_rs[s*REG_W +: REG_W] == {REG_W{1'b0}}) ? OP_READY : OP_PEND;
          end
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Flag responses whose tag does not name an in-flight operand.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst_n && rsp_valid[b] && !rsp_ok_s[b]) begin
        $error("operand collector: bank %0d response tag %0h not in flight", b, rsp_tag[b*TAG_W +: TAG_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gelato_operand_collector_banked.sv
// Directed bench for the banked operand collector with hand-computed expectations.
module tb_gelato_operand_collector_banked;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         rdy;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_inst;
  logic [14:0]  in_rs;
  logic [1:0]   in_warp;
  logic [1:0]   in_unit;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [27:0]  req_reg;
  logic [15:0]  req_tag;
  logic [3:0]   rsp_valid;
  logic [15:0]  rsp_tag;
  logic [127:0] rsp_data;
  logic [2:0]   disp_valid;
  logic [2:0]   disp_ready;
  logic [191:0] disp_inst;
  logic [287:0] disp_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gelato_operand_collector_banked dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_rs(in_rs),
    .in_warp(in_warp), .in_unit(in_unit),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst), .disp_src(disp_src)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_inst = 64'h0; in_rs = 15'h0;
    in_warp = 2'd0; in_unit = 2'd0; req_ready = 4'hF; rsp_valid = 4'h0;
    rsp_tag = 16'h0; rsp_data = 128'h0; disp_ready = 3'b000;
    tick; tick;
    checks++; if ({in_ready, req_valid, disp_valid} !== 8'h00) begin errors++;
      $display("FAIL reset_outputs got %h exp 00", {in_ready, req_valid, disp_valid}); end
    rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_zero_src;
    in_valid = 1'b1; in_rs = 15'h0; in_warp = 2'd0; in_unit = 2'd1; in_inst = 64'hCAFE_0000_0000_0001;
    tick; in_valid = 1'b0; #1;
    checks++; if (disp_valid !== 3'b010) begin errors++; $display("FAIL zero_disp_valid got %b exp 010", disp_valid); end
    checks++; if (disp_inst[64 +: 64] !== 64'hCAFE_0000_0000_0001) begin errors++;
      $display("FAIL zero_disp_inst got %h exp cafe000000000001", disp_inst[64 +: 64]); end
    checks++; if (disp_src[96 +: 96] !== 96'h0) begin errors++; $display("FAIL zero_disp_src got %h exp 0", disp_src[96 +: 96]); end
    checks++; if (req_valid !== 4'h0) begin errors++; $display("FAIL zero_no_req got %b exp 0000", req_valid); end
    disp_ready = 3'b010; tick; disp_ready = 3'b000; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL zero_after_disp got %b exp 000", disp_valid); end
  endtask

  task automatic test_banks;
    in_valid = 1'b1; in_rs = {5'd3, 5'd2, 5'd1}; in_warp = 2'd1; in_unit = 2'd0; in_inst = 64'h2;
    tick; in_valid = 1'b0; #1;
    checks++; if (req_valid !== 4'b1110) begin errors++; $display("FAIL banks_req_valid got %b exp 1110", req_valid); end
    checks++; if ({req_reg[21 +: 7], req_reg[14 +: 7], req_reg[7 +: 7]} !== {7'h23, 7'h22, 7'h21}) begin errors++;
      $display("FAIL banks_req_reg got %h exp 23/22/21", req_reg); end
    checks++; if ({req_tag[12 +: 4], req_tag[8 +: 4], req_tag[4 +: 4]} !== 12'h210) begin errors++;
      $display("FAIL banks_req_tag got %h exp 210", req_tag[15:4]); end
    tick;
    checks++; if (req_valid !== 4'h0) begin errors++; $display("FAIL banks_inflight got %b exp 0000", req_valid); end
    tick;
    rsp_valid = 4'b1110; rsp_tag = {4'h2, 4'h1, 4'h0, 4'h0}; rsp_data = {32'hC, 32'hB, 32'hA, 32'h0};
    #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL banks_early_disp got %b exp 000", disp_valid); end
    tick; rsp_valid = 4'h0; #1;
    checks++; if (disp_valid !== 3'b001) begin errors++; $display("FAIL banks_disp_valid got %b exp 001", disp_valid); end
    checks++; if (disp_src[0 +: 96] !== {32'hC, 32'hB, 32'hA}) begin errors++;
      $display("FAIL banks_disp_src got %h exp c/b/a", disp_src[0 +: 96]); end
    disp_ready = 3'b001; tick; disp_ready = 3'b000; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL banks_after_disp got %b exp 000", disp_valid); end
  endtask

  task automatic test_bank_conflict;
    req_ready = 4'b1110;
    in_valid = 1'b1; in_rs = {5'd0, 5'd0, 5'd4}; in_warp = 2'd0; in_unit = 2'd2; in_inst = 64'h3;
    tick; in_inst = 64'h4;
    tick; in_valid = 1'b0; #1;
    checks++; if ({req_valid[0], req_tag[3:0], req_reg[6:0]} !== {1'b1, 4'h0, 7'h04}) begin errors++;
      $display("FAIL conflict_held got v%b t%h r%h exp v1 t0 r04", req_valid[0], req_tag[3:0], req_reg[6:0]); end
    req_ready = 4'hF; tick;
    checks++; if ({req_valid[0], req_tag[3:0]} !== {1'b1, 4'h4}) begin errors++;
      $display("FAIL conflict_second got v%b t%h exp v1 t4", req_valid[0], req_tag[3:0]); end
    tick;
    checks++; if (req_valid[0] !== 1'b0) begin errors++; $display("FAIL conflict_done got %b exp 0", req_valid[0]); end
    rsp_valid = 4'b0001; rsp_tag = 16'h0000; rsp_data = {96'h0, 32'h11};
    tick;
    checks++; if ({disp_valid, disp_inst[128 +: 64], disp_src[192 +: 32]} !== {3'b100, 64'h3, 32'h11}) begin errors++;
      $display("FAIL conflict_disp0 got v%b i%h s%h exp v100 i3 s11", disp_valid, disp_inst[128 +: 64], disp_src[192 +: 32]); end
    rsp_tag = 16'h0004; rsp_data = {96'h0, 32'h22};
    tick; rsp_valid = 4'h0; disp_ready = 3'b100; #1;
    checks++; if (disp_inst[128 +: 64] !== 64'h3) begin errors++; $display("FAIL conflict_lock got %h exp 3", disp_inst[128 +: 64]); end
    tick;
    checks++; if ({disp_valid[2], disp_inst[128 +: 64], disp_src[192 +: 32]} !== {1'b1, 64'h4, 32'h22}) begin errors++;
      $display("FAIL conflict_disp1 got v%b i%h s%h exp v1 i4 s22", disp_valid[2], disp_inst[128 +: 64], disp_src[192 +: 32]); end
    tick; disp_ready = 3'b000; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL conflict_drained got %b exp 000", disp_valid); end
  endtask

  task automatic test_full;
    logic [63:0] exp_inst [4];
    exp_inst = '{64'h11, 64'h12, 64'h13, 64'h15};
    disp_ready = 3'b000; in_valid = 1'b1; in_rs = 15'h0; in_unit = 2'd1; in_warp = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_inst = 64'h10 + 64'(i);
      tick;
    end
    in_inst = 64'h15; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if ({disp_valid, disp_inst[64 +: 64]} !== {3'b010, 64'h10}) begin errors++;
      $display("FAIL full_first_disp got v%b i%h exp v010 i10", disp_valid, disp_inst[64 +: 64]); end
    disp_ready = 3'b010; tick; disp_ready = 3'b000; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_freed got %b exp 1", in_ready); end
    checks++; if (disp_inst[64 +: 64] !== 64'h11) begin errors++; $display("FAIL full_rr_next got %h exp 11", disp_inst[64 +: 64]); end
    tick; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refilled got %b exp 0", in_ready); end
    disp_ready = 3'b010; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({disp_valid[1], disp_inst[64 +: 64]} !== {1'b1, exp_inst[i]}) begin errors++;
        $display("FAIL full_drain%0d got v%b i%h exp v1 i%h", i, disp_valid[1], disp_inst[64 +: 64], exp_inst[i]); end
      tick;
    end
    disp_ready = 3'b000; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL full_empty got %b exp 000", disp_valid); end
  endtask

  task automatic test_stall;
    in_valid = 1'b1; in_rs = {5'd0, 5'd0, 5'd1}; in_warp = 2'd0; in_unit = 2'd0; in_inst = 64'h20;
    tick; in_valid = 1'b0; #1;
    checks++; if ({req_valid, req_tag[7:4]} !== {4'b0010, 4'h0}) begin errors++;
      $display("FAIL stall_req got v%b t%h exp v0010 t0", req_valid, req_tag[7:4]); end
    tick; rdy = 1'b0; #1;
    checks++; if ({in_ready, req_valid, disp_valid} !== 8'h00) begin errors++;
      $display("FAIL stall_outputs got %h exp 00", {in_ready, req_valid, disp_valid}); end
    rsp_valid = 4'b0010; rsp_tag = 16'h0000; rsp_data = {32'h0, 32'h0, 32'h55, 32'h0};
    tick; rsp_valid = 4'h0; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL stall_disp_blocked got %b exp 000", disp_valid); end
    tick; tick; rdy = 1'b1; #1;
    checks++; if ({disp_valid, disp_src[31:0], in_ready} !== {3'b001, 32'h55, 1'b1}) begin errors++;
      $display("FAIL stall_resume got v%b s%h r%b exp v001 s55 r1", disp_valid, disp_src[31:0], in_ready); end
    disp_ready = 3'b001; tick; disp_ready = 3'b000; #1;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL stall_drained got %b exp 000", disp_valid); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_rs = {5'd0, 5'd0, 5'd1}; in_warp = 2'd0; in_unit = 2'd1; in_inst = 64'h30;
    tick; in_rs = {5'd0, 5'd0, 5'd2}; in_inst = 64'h31;
    tick; in_valid = 1'b0;
    tick;
    checks++; if (req_valid !== 4'h0) begin errors++; $display("FAIL rmid_inflight got %b exp 0000", req_valid); end
    rst_n = 1'b0; tick;
    checks++; if ({in_ready, req_valid, disp_valid} !== 8'h00) begin errors++;
      $display("FAIL rmid_outputs got %h exp 00", {in_ready, req_valid, disp_valid}); end
    rsp_valid = 4'b0110; rsp_tag = {4'h0, 4'h4, 4'h0, 4'h0}; rsp_data = {32'h0, 32'h77, 32'h66, 32'h0};
    tick; rsp_valid = 4'h0; rst_n = 1'b1; #1;
    checks++; if ({disp_valid, req_valid, in_ready} !== 8'h01) begin errors++;
      $display("FAIL rmid_after got %h exp 01", {disp_valid, req_valid, in_ready}); end
    tick; tick;
    checks++; if (disp_valid !== 3'b000) begin errors++; $display("FAIL rmid_no_disp got %b exp 000", disp_valid); end
  endtask

  initial begin
    test_reset;
    test_zero_src;
    test_banks;
    test_bank_conflict;
    test_full;
    test_stall;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
